// File: rtl/sdram_stream_unpacker_pkg.sv
// Shared types and helpers for the SDRAM stream unpacker and its FIFO.
package sdram_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    READ,
    UNPACK,
    DRAIN_ABORT,
    DONE
  } state_t;

  typedef enum logic {
    MODE_ELEM   = 1'b0,
    MODE_WORD32 = 1'b1
  } mode_t;

  // Number of elements carried by one bridge word in the given mode.
  function automatic int unsigned elems_per_word(mode_t mode,
                                                 int unsigned iface_w = 128,
                                                 int unsigned elem_w  = 8);
    if (mode == MODE_WORD32) return iface_w / 32;
    else                     return iface_w / elem_w;
  endfunction

endpackage

// File: rtl/sdram_stream_unpacker_stream_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy level.
// The head entry is visible on pop_data whenever empty is low.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == LW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign level    = count;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sdram_stream_unpacker.sv
// Fetches a run of bridge words from SDRAM, splits each word LSB-first into
// pixel or 32-bit elements, and streams them out through an element FIFO.
module sdram_stream_unpacker
  import sdram_stream_pkg::*;
#(
  parameter int INTERFACE_WIDTH_BITS = 128,
  parameter int INTERFACE_ADDR_BITS  = 26,
  parameter int ELEM_WIDTH           = 8,
  parameter int FIFO_DEPTH           = 64,
  parameter int COUNT_BITS           = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [INTERFACE_ADDR_BITS-1:0]      base_address,
  input  logic [COUNT_BITS-1:0]               num_words,
  input  logic                                mode,
  input  logic                                abort,
  output logic [INTERFACE_ADDR_BITS-1:0]      interface_address,
  output logic [INTERFACE_WIDTH_BITS/8-1:0]   interface_byte_enable,
  output logic                                interface_read,
  input  logic [INTERFACE_WIDTH_BITS-1:0]     interface_read_data,
  input  logic                                interface_acknowledge,
  output logic [31:0]                         out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic                                busy,
  output logic                                done
);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FREE_W = LVL_W + 1;
  localparam int E_MAX  = INTERFACE_WIDTH_BITS / ELEM_WIDTH;
  localparam int E_32   = INTERFACE_WIDTH_BITS / 32;
  localparam int IDX_W  = (E_MAX > 1) ? $clog2(E_MAX) : 1;
  localparam int BYTES  = INTERFACE_WIDTH_BITS / 8;

  state_t                          state_q, state_d;
  logic [INTERFACE_ADDR_BITS-1:0]  addr_q;
  logic [COUNT_BITS-1:0]           words_left_q;
  mode_t                           mode_q;
  logic [IDX_W-1:0]                idx_q;
  logic [INTERFACE_WIDTH_BITS-1:0] word_q;

  logic                  load_run;
  logic                  capture;
  logic                  word_done;
  logic                  fifo_push;
  logic                  fifo_flush;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop_fire;
  logic                  space_ok;
  logic                  last_elem;
  logic [31:0]           e_cur;
  logic [FREE_W-1:0]     free_space;
  logic [ELEM_WIDTH-1:0] lane_narrow;
  logic [31:0]           lane_word;
  logic [31:0]           elem;

  assign interface_address     = addr_q;
  assign interface_byte_enable = '1;
  assign interface_read        = (state_q == READ) || (state_q == DRAIN_ABORT);
  assign busy                  = (state_q != IDLE);
  assign done                  = (state_q == DONE) && !abort;
  assign out_valid             = ~fifo_empty;
  assign pop_fire              = out_ready & out_valid;

  // Space check counts a pop happening this cycle so a read can be issued as soon as room appears.
  always_comb begin
    e_cur      = elems_per_word(mode_q, INTERFACE_WIDTH_BITS, ELEM_WIDTH);
    free_space = FREE_W'(FIFO_DEPTH) - {1'b0, fifo_level} + FREE_W'(pop_fire);
    space_ok   = 32'(free_space) >= e_cur;
    last_elem  = 32'(idx_q) == (e_cur - 32'd1);
  end

  // Select element idx_q of the captured word, zero-extending narrow pixels.
  always_comb begin
    lane_narrow = '0;
    lane_word   = '0;
    for (int i = 0; i < E_MAX; i++) begin
      if (idx_q == IDX_W'(i)) lane_narrow = word_q[i*ELEM_WIDTH +: ELEM_WIDTH];
    end
    for (int i = 0; i < E_32; i++) begin
      if (idx_q == IDX_W'(i)) lane_word = word_q[i*32 +: 32];
    end
    elem = (mode_q == MODE_WORD32) ? lane_word : 32'(lane_narrow);
  end

  // Next-state and per-cycle control; abort takes priority over every other request.
  always_comb begin
    state_d    = state_q;
    load_run   = 1'b0;
    capture    = 1'b0;
    word_done  = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      IDLE: begin
        if (abort) begin
          fifo_flush = 1'b1;
        end else if (start) begin
          if (num_words != '0) begin
            load_run = 1'b1;
            state_d  = WAIT_SPACE;
          end else begin
            state_d  = DONE;
          end
        end
      end
      WAIT_SPACE: begin
        if (abort) begin
          fifo_flush = 1'b1;
          state_d    = IDLE;
        end else if (space_ok) begin
          state_d    = READ;
        end
      end
      READ: begin
        if (abort) begin
          fifo_flush = 1'b1;
          // An ack in the abort cycle already completes the bridge transfer.
          state_d    = interface_acknowledge ? IDLE : DRAIN_ABORT;
        end else if (interface_acknowledge) begin
          capture    = 1'b1;
          state_d    = UNPACK;
        end
      end
      UNPACK: begin
        if (abort) begin
          fifo_flush = 1'b1;
          state_d    = IDLE;
        end else if (~fifo_full | pop_fire) begin
          fifo_push = 1'b1;
          if (last_elem) begin
            word_done = 1'b1;
            state_d   = (words_left_q == COUNT_BITS'(1)) ? DONE : WAIT_SPACE;
          end
        end
      end
      DRAIN_ABORT: begin
        if (interface_acknowledge) begin
          fifo_flush = 1'b1;
          state_d    = IDLE;
        end
      end
      DONE: begin
        if (abort) fifo_flush = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Run bookkeeping: address, remaining word count, element mode and element index.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      words_left_q <= '0;
      mode_q       <= MODE_ELEM;
      idx_q        <= '0;
    end else begin
      if (load_run) begin
        addr_q       <= base_address;
        words_left_q <= num_words;
        mode_q       <= mode_t'(mode);
      end
      if (capture) begin
        idx_q <= '0;
      end else if (fifo_push) begin
        idx_q <= last_elem ? '0 : idx_q + IDX_W'(1);
      end
      if (word_done) begin
        words_left_q <= words_left_q - COUNT_BITS'(1);
        addr_q       <= addr_q + INTERFACE_ADDR_BITS'(BYTES);
      end
    end
  end

  // Word register loaded on the acknowledge cycle of a normal read.
  always_ff @(posedge clk) begin
    if (capture) word_q <= interface_read_data;
  end

  stream_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (elem),
    .pop       (out_ready),
    .pop_data  (out_data),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
